sfifo_pkt: RTL



---
 rtl/sfifo_pkt.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sfifo_pkt.sv
// Synchronous packet FIFO: show-ahead read, per-packet commit/discard on the write side.
// Optional drop statistics counter enabled by defining SFIFO_PKT_DROP_STAT_EN.
module sfifo_pkt #(
    parameter int    WIDTH   = 8,
    parameter int    DEPTH   = 16,
    parameter string RAMTYPE = "AUTO"
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         wr_req,
    input  logic                         wr_eop,
    input  logic                         wr_drop,
    output logic                         wr_full,
    output logic                         wr_dropped,
    output logic [$clog2(DEPTH+1)-1:0]   free,
    output logic [$clog2(DEPTH+1)-1:0]   used,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_cnt,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_eop,
    input  logic                         rd_req,
    output logic                         rd_empty,
    output logic [15:0]                  drop_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_DISCARD
    } state_t;

    (* ramstyle = RAMTYPE *) logic [WIDTH:0] mem [DEPTH];

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [PW-1:0]   commit_cnt_q, commit_cnt_d;
    logic [PW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]   used_q, used_d;
    logic [CW-1:0]   unc_q, unc_d;
    logic [CW-1:0]   pkt_q, pkt_d;
    logic            wr_dropped_q;
    logic            store, commit, drop_evt;
    logic            rd_ena;
    logic [WIDTH:0]  head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head     = mem[rd_cnt_q];
    assign rd_empty = (used_q == '0);
    assign rd_ena   = rd_req & ~rd_empty;
    assign wr_full  = ((used_q + unc_q) == DEPTH_C);
    assign free     = DEPTH_C - used_q - unc_q;
    assign used     = used_q;
    assign pkt_cnt  = pkt_q;
    assign rd_data  = rd_empty ? '0 : head[WIDTH-1:0];
    assign rd_eop   = ~rd_empty & head[WIDTH];
    assign wr_dropped = wr_dropped_q;

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        commit_cnt_d = commit_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        unc_d        = unc_q;
        store        = 1'b0;
        commit       = 1'b0;
        drop_evt     = 1'b0;

        case (state_q)
            S_IDLE, S_OPEN: begin
                if (state_q == S_OPEN && wr_drop) begin
                    drop_evt = 1'b1;
                    wr_cnt_d = commit_cnt_q;
                    unc_d    = '0;
                    state_d  = S_IDLE;
                end else if (wr_req && !wr_full) begin
                    store    = 1'b1;
                    wr_cnt_d = ptr_inc(wr_cnt_q);
                    if (wr_eop) begin
                        commit       = 1'b1;
                        commit_cnt_d = ptr_inc(wr_cnt_q);
                        unc_d        = '0;
                        state_d      = S_IDLE;
                    end else begin
                        unc_d   = unc_q + CW'(1);
                        state_d = S_OPEN;
                    end
                end else if (wr_req) begin
                    // Overflow: rewind and swallow the tail unless this was the last word
                    drop_evt = 1'b1;
                    wr_cnt_d = commit_cnt_q;
                    unc_d    = '0;
                    state_d  = wr_eop ? S_IDLE : S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (wr_drop || (wr_req && wr_eop))
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (rd_ena)
            rd_cnt_d = ptr_inc(rd_cnt_q);

        used_d = used_q;
        if (rd_ena)
            used_d = used_d - CW'(1);
        if (commit)
            used_d = used_d + unc_q + CW'(1);

        pkt_d = pkt_q;
        if (rd_ena && head[WIDTH])
            pkt_d = pkt_d - CW'(1);
        if (commit)
            pkt_d = pkt_d + CW'(1);

        if (clear) begin
            state_d      = S_IDLE;
            wr_cnt_d     = '0;
            commit_cnt_d = '0;
            rd_cnt_d     = '0;
            used_d       = '0;
            unc_d        = '0;
            pkt_d        = '0;
            store        = 1'b0;
            commit       = 1'b0;
            drop_evt     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_cnt_q     <= '0;
            commit_cnt_q <= '0;
            rd_cnt_q     <= '0;
            used_q       <= '0;
            unc_q        <= '0;
            pkt_q        <= '0;
            wr_dropped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            commit_cnt_q <= commit_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            used_q       <= used_d;
            unc_q        <= unc_d;
            pkt_q        <= pkt_d;
            wr_dropped_q <= drop_evt;
        end
    end

    // Storage is never reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (store)
            mem[wr_cnt_q] <= {wr_eop, wr_data};
    end

`ifdef SFIFO_PKT_DROP_STAT_EN
    logic [15:0] drop_cnt_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt_q <= '0;
        else if (clear)
            drop_cnt_q <= '0;
        else if (drop_evt)
            drop_cnt_q <= sat_inc16(drop_cnt_q);
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule
